qspi_bus_arbiter: RTL

QSPI_BUS_ARBITER -- requirements
Module: qspi_bus_arbiter

---
 rtl/qspi_bus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/qspi_bus_arbiter.sv
// Two-client QSPI pad arbiter: grants the shared pad bus to the PSRAM (client 0) or
// NOR flash (client 1) controller, with a fixed idle turnaround between owners.
module qspi_bus_arbiter #(
    parameter int TURN_CYC = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       c0_req,
    input  logic       c1_req,
    output logic       c0_gnt,
    output logic       c1_gnt,
    input  logic       c0_ce_n,
    input  logic       c1_ce_n,
    input  logic       c0_sclk,
    input  logic       c1_sclk,
    input  logic [3:0] c0_sio_o,
    input  logic [3:0] c1_sio_o,
    input  logic [3:0] c0_sio_oe,
    input  logic [3:0] c1_sio_oe,
    output logic [3:0] c0_sio_i,
    output logic [3:0] c1_sio_i,
    output logic       ce0,
    output logic       ce1,
    output logic       sclk_ram,
    output logic       sclk_nor,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    input  logic [3:0] sio_i,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_armed;

    // On a tie the client that was not served last wins.
    function automatic state_t pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1)
            return last ? ST_GNT0 : ST_GNT1;
        else if (req0)
            return ST_GNT0;
        else if (req1)
            return ST_GNT1;
        else
            return ST_IDLE;
    endfunction

    // r_armed holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_armed)
                    w_state_nxt = pick(c0_req, c1_req, r_last);
            end
            ST_GNT0: begin
                if (!c0_req) begin
                    w_state_nxt = ST_TURN;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = TURN_LOAD;
                end
            end
            ST_GNT1: begin
                if (!c1_req) begin
                    w_state_nxt = ST_TURN;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = pick(c0_req, c1_req, r_last);
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign c0_gnt = (r_state == ST_GNT0);
    assign c1_gnt = (r_state == ST_GNT1);
    assign busy   = (r_state != ST_IDLE);

    // Pad mux decodes only the registered state, so no req-to-pad path exists.
    always_comb begin
        ce0      = 1'b1;
        ce1      = 1'b1;
        sclk_ram = 1'b0;
        sclk_nor = 1'b0;
        sio_o    = 4'h0;
        sio_oe   = 4'h0;
        c0_sio_i = 4'h0;
        c1_sio_i = 4'h0;
        case (r_state)
            ST_GNT0: begin
                ce0      = c0_ce_n;
                sclk_ram = c0_sclk;
                sio_o    = c0_sio_o;
                sio_oe   = c0_sio_oe;
                c0_sio_i = sio_i;
            end
            ST_GNT1: begin
                ce1      = c1_ce_n;
                sclk_nor = c1_sclk;
                sio_o    = c1_sio_o;
                sio_oe   = c1_sio_oe;
                c1_sio_i = sio_i;
            end
            default: ;
        endcase
    end

endmodule
